// File: rtl/glb_pkg.sv
// rtl/glb_pkg.sv - shared types and constants for the global buffer
package glb_pkg;

    localparam int GLB_BUFFER_SIZE = 512;
    localparam int GLB_ADDR_W      = $clog2(GLB_BUFFER_SIZE);

    // Read scheduler phases
    typedef enum logic [2:0] {
        S_IDLE,
        S_FLTR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } glb_sched_state_t;

    // Data-type codes, shared with the write side of the buffer
    typedef enum logic [1:0] {
        DT_IDLE,
        DT_IFMAP,
        DT_FLTR,
        DT_PSUM
    } glb_data_type_t;

endpackage

// File: rtl/glb_valid_pipe.sv
// rtl/glb_valid_pipe.sv - read-latency matched valid shift register
module glb_valid_pipe #(
    parameter int RD_LATENCY = 1
) (
    input  logic bus_clk,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic inflight
);

    logic [RD_LATENCY-1:0] sr;

    // Shift the issued-read flag along; clr drops everything in flight
    always_ff @(posedge bus_clk) begin
        if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < RD_LATENCY; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[RD_LATENCY-1];

    // Words that will still be in the pipe after this cycle (all but the output stage)
    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            inflight = inflight | sr[i];
        end
    end

endmodule

// File: rtl/glb_read_sched.sv
// rtl/glb_read_sched.sv - port-B read scheduler for the ifmap/filter/psum RAMs
module glb_read_sched
    import glb_pkg::*;
#(
    parameter  int BUFFER_SIZE = GLB_BUFFER_SIZE,
    parameter  int NUM_COL     = 8,
    parameter  int NUM_ROW     = 8,
    parameter  int RD_LATENCY  = 1,
    localparam int ADDR_W      = $clog2(BUFFER_SIZE),
    localparam int XT_W        = $clog2(NUM_COL) + 1
) (
    input  logic              bus_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        kernel_size,
    input  logic [ADDR_W:0]   fltr_count,
    input  logic [ADDR_W:0]   ifmap_count,
    input  logic              pe_ready,
    input  logic              ram_rst_busy,
    output logic              fltr_rd_en,
    output logic [ADDR_W-1:0] fltr_rd_addr,
    output logic              ifmap_rd_en,
    output logic [ADDR_W-1:0] ifmap_rd_addr,
    output logic              psum_rd_en,
    output logic [ADDR_W-1:0] psum_rd_addr,
    output logic [XT_W-1:0]   x_tag,
    output logic              flush_tag,
    output logic              fltr_valid,
    output logic              data_valid,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    if (RD_LATENCY < 1 || RD_LATENCY > 3 || NUM_ROW < 1 || NUM_COL < 1) begin : g_param_check
        $error("glb_read_sched: unsupported parameter set");
    end

    glb_sched_state_t  state_q, state_d;
    logic [7:0]        kernel_q;
    logic [ADDR_W:0]   fltr_cnt_q, ifmap_cnt_q, rd_cnt_q;
    logic [ADDR_W-1:0] fltr_addr_q, strm_addr_q;
    logic [XT_W-1:0]   x_tag_q;
    logic              start_ok, cfg_ok, fltr_last, strm_last, x_wrap;
    logic              fltr_inflight, data_inflight, pipe_clr;

    assign start_ok  = start && !ram_rst_busy && (state_q == S_IDLE);
    assign cfg_ok    = (kernel_size != 8'd0) && (kernel_size <= 8'(NUM_COL)) &&
                       (fltr_count != '0) && (fltr_count <= (ADDR_W+1)'(BUFFER_SIZE)) &&
                       (ifmap_count != '0) && (ifmap_count <= (ADDR_W+1)'(BUFFER_SIZE));
    assign fltr_last = (rd_cnt_q == fltr_cnt_q - (ADDR_W+1)'(1));
    assign strm_last = (rd_cnt_q == ifmap_cnt_q - (ADDR_W+1)'(1));
    assign x_wrap    = (8'(x_tag_q) == kernel_q - 8'd1);
    assign pipe_clr  = rst || (abort && state_q != S_IDLE);

    // Phase sequencing and read strobes; abort wins over everything else
    always_comb begin
        state_d     = state_q;
        fltr_rd_en  = 1'b0;
        ifmap_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok && cfg_ok) state_d = S_FLTR;
            end
            S_FLTR: begin
                fltr_rd_en = pe_ready && !abort;
                if (fltr_rd_en && fltr_last) state_d = S_STREAM;
            end
            S_STREAM: begin
                ifmap_rd_en = pe_ready && !abort;
                if (ifmap_rd_en && strm_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!fltr_inflight && !data_inflight) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    // State register
    always_ff @(posedge bus_clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Job config capture, address/tag counters and the cfg_err pulse
    always_ff @(posedge bus_clk) begin
        if (rst) begin
            kernel_q    <= '0;
            fltr_cnt_q  <= '0;
            ifmap_cnt_q <= '0;
            rd_cnt_q    <= '0;
            fltr_addr_q <= '0;
            strm_addr_q <= '0;
            x_tag_q     <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= start_ok && !cfg_ok;
            if (start_ok) begin
                kernel_q    <= kernel_size;
                fltr_cnt_q  <= fltr_count;
                ifmap_cnt_q <= ifmap_count;
            end
            if (state_d == S_IDLE) begin
                rd_cnt_q    <= '0;
                fltr_addr_q <= '0;
                strm_addr_q <= '0;
                x_tag_q     <= '0;
            end else if (fltr_rd_en) begin
                // The issued counter restarts for the stream phase; addresses stop at the last word
                if (fltr_last) begin
                    rd_cnt_q <= '0;
                end else begin
                    rd_cnt_q    <= rd_cnt_q + (ADDR_W+1)'(1);
                    fltr_addr_q <= fltr_addr_q + ADDR_W'(1);
                end
            end else if (ifmap_rd_en) begin
                x_tag_q <= x_wrap ? '0 : x_tag_q + XT_W'(1);
                if (!strm_last) begin
                    rd_cnt_q    <= rd_cnt_q + (ADDR_W+1)'(1);
                    strm_addr_q <= strm_addr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign fltr_rd_addr  = fltr_addr_q;
    assign ifmap_rd_addr = strm_addr_q;
    assign psum_rd_addr  = strm_addr_q;
    assign psum_rd_en    = ifmap_rd_en;
    assign flush_tag     = ifmap_rd_en;
    assign x_tag         = x_tag_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

    glb_valid_pipe #(.RD_LATENCY(RD_LATENCY)) u_fltr_vpipe (
        .bus_clk  (bus_clk),
        .clr      (pipe_clr),
        .din      (fltr_rd_en),
        .dout     (fltr_valid),
        .inflight (fltr_inflight)
    );

    glb_valid_pipe #(.RD_LATENCY(RD_LATENCY)) u_data_vpipe (
        .bus_clk  (bus_clk),
        .clr      (pipe_clr),
        .din      (ifmap_rd_en),
        .dout     (data_valid),
        .inflight (data_inflight)
    );

endmodule
